// File: rtl/mp_pipe_if.sv
// rtl/mp_pipe_if.sv - instruction/result handshake bundle for mp_pipe
//
// Signals:
//   instr, instr_valid, instr_ready         instruction input handshake
//   result, result_rd, result_valid,
//   result_ready                            result output handshake
// Modports:
//   slave  - the core (accepts instr, produces result)
//   master - the instruction source / result consumer
interface mp_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic [31:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] result;
  logic [REG_AW-1:0] result_rd;
  logic              result_valid;
  logic              result_ready;

  modport slave (
    input  instr, instr_valid, result_ready,
    output instr_ready, result, result_rd, result_valid
  );

  modport master (
    output instr, instr_valid, result_ready,
    input  instr_ready, result, result_rd, result_valid
  );
endinterface

// File: rtl/mp_pipe.sv
// rtl/mp_pipe.sv - 2-stage pipelined ALU/register-file core
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     mp_pipe_if.slave: instr/instr_valid/instr_ready in,
//           result/result_rd/result_valid/result_ready out
//   flag_z, flag_n, flag_v  status flags registered with result
//                           (present only with MP_PIPE_FLAGS_EN defined)
//
// Instruction word: [5:0] opcode, [10:6] rs1, [15:11] rs2, [20:16] rd,
// [31:21] imm11. S1 holds decoded operands, S2 holds the result and the
// register file is written as S1 advances into S2.
module mp_pipe #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int OPC_W  = 6,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic clk,
  input  logic rst_n,
`ifdef MP_PIPE_FLAGS_EN
  output logic flag_z,
  output logic flag_n,
  output logic flag_v,
`endif
  mp_pipe_if.slave bus
);

  localparam logic [OPC_W-1:0] OP_ADD = 6'b001000;
  localparam logic [OPC_W-1:0] OP_SUB = 6'b001001;
  localparam logic [OPC_W-1:0] OP_ABS = 6'b000010;
  localparam logic [OPC_W-1:0] OP_NEG = 6'b001010;
  localparam logic [OPC_W-1:0] OP_MAX = 6'b001100;
  localparam logic [OPC_W-1:0] OP_MIN = 6'b000001;
  localparam logic [OPC_W-1:0] OP_AVG = 6'b001101;
  localparam logic [OPC_W-1:0] OP_NOT = 6'b000101;
  localparam logic [OPC_W-1:0] OP_OR  = 6'b000100;
  localparam logic [OPC_W-1:0] OP_AND = 6'b001011;
  localparam logic [OPC_W-1:0] OP_XOR = 6'b001111;
  localparam logic [OPC_W-1:0] OP_LDI = 6'b000011;
  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] rf [NREG];

  logic              s1_valid;
  logic [OPC_W-1:0]  s1_opc;
  logic [REG_AW-1:0] s1_rd;
  logic [10:0]       s1_imm;
  logic [DATA_W-1:0] s1_a, s1_b;

  logic [DATA_W-1:0] alu_y;
  logic              alu_wr, alu_v;
  logic [DATA_W-1:0] add_y, sub_y, neg_y;
  logic [DATA_W:0]   sum_ext;

  logic              stall, fwd_ok, wr_en;
  logic [REG_AW-1:0] rs1, rs2, rd_in;
  logic [DATA_W-1:0] op_a, op_b;

  assign stall           = bus.result_valid & ~bus.result_ready;
  assign bus.instr_ready = ~stall;

  assign rs1   = bus.instr[6  +: REG_AW];
  assign rs2   = bus.instr[11 +: REG_AW];
  assign rd_in = bus.instr[16 +: REG_AW];

  // S1's result lands in the register file on the same edge that the
  // incoming instruction is captured, so bypass it from the ALU output.
  assign fwd_ok = s1_valid & alu_wr & (s1_rd != '0);
  assign op_a   = (fwd_ok && s1_rd == rs1) ? alu_y : rf[rs1];
  assign op_b   = (fwd_ok && s1_rd == rs2) ? alu_y : rf[rs2];

  assign add_y   = s1_a + s1_b;
  assign sub_y   = s1_a - s1_b;
  assign neg_y   = '0 - s1_a;
  assign sum_ext = {1'b0, s1_a} + {1'b0, s1_b};

  always_comb begin
    alu_y  = '0;
    alu_wr = 1'b1;
    alu_v  = 1'b0;
    case (s1_opc)
      OP_ADD: begin
        alu_y = add_y;
        alu_v = (s1_a[MSB] == s1_b[MSB]) && (add_y[MSB] != s1_a[MSB]);
      end
      OP_SUB: begin
        alu_y = sub_y;
        alu_v = (s1_a[MSB] != s1_b[MSB]) && (sub_y[MSB] != s1_a[MSB]);
      end
      OP_NEG: begin
        alu_y = neg_y;
        // only the most negative value negates to itself
        alu_v = s1_a[MSB] & neg_y[MSB];
      end
      OP_ABS: alu_y = s1_a[MSB] ? neg_y : s1_a;
      OP_MAX: alu_y = (s1_a > s1_b) ? s1_a : s1_b;
      OP_MIN: alu_y = (s1_a < s1_b) ? s1_a : s1_b;
      OP_AVG: alu_y = sum_ext[DATA_W:1];
      OP_NOT: alu_y = ~s1_a;
      OP_OR:  alu_y = s1_a | s1_b;
      OP_AND: alu_y = s1_a & s1_b;
      OP_XOR: alu_y = s1_a ^ s1_b;
      OP_LDI: alu_y = {{(DATA_W-11){1'b0}}, s1_imm};
      default: alu_wr = 1'b0;
    endcase
  end

  assign wr_en = ~stall & fwd_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[s1_rd] <= alu_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid         <= 1'b0;
      s1_opc           <= '0;
      s1_rd            <= '0;
      s1_imm           <= '0;
      s1_a             <= '0;
      s1_b             <= '0;
      bus.result       <= '0;
      bus.result_rd    <= '0;
      bus.result_valid <= 1'b0;
`ifdef MP_PIPE_FLAGS_EN
      flag_z           <= 1'b0;
      flag_n           <= 1'b0;
      flag_v           <= 1'b0;
`endif
    end else if (!stall) begin
      s1_valid <= bus.instr_valid;
      if (bus.instr_valid) begin
        s1_opc <= bus.instr[OPC_W-1:0];
        s1_rd  <= rd_in;
        s1_imm <= bus.instr[31:21];
        s1_a   <= op_a;
        s1_b   <= op_b;
      end
      bus.result_valid <= s1_valid;
      if (s1_valid) begin
        bus.result    <= alu_y;
        bus.result_rd <= s1_rd;
`ifdef MP_PIPE_FLAGS_EN
        flag_z        <= (alu_y == '0);
        flag_n        <= alu_y[MSB];
        flag_v        <= alu_v;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mp_pipe.sv
// tb/tb_mp_pipe.sv - scoreboard testbench for mp_pipe
module tb_mp_pipe;

  localparam logic [5:0] OP_ADD = 6'b001000;
  localparam logic [5:0] OP_SUB = 6'b001001;
  localparam logic [5:0] OP_ABS = 6'b000010;
  localparam logic [5:0] OP_NEG = 6'b001010;
  localparam logic [5:0] OP_MAX = 6'b001100;
  localparam logic [5:0] OP_MIN = 6'b000001;
  localparam logic [5:0] OP_AVG = 6'b001101;
  localparam logic [5:0] OP_NOT = 6'b000101;
  localparam logic [5:0] OP_OR  = 6'b000100;
  localparam logic [5:0] OP_AND = 6'b001011;
  localparam logic [5:0] OP_XOR = 6'b001111;
  localparam logic [5:0] OP_LDI = 6'b000011;
  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

`ifdef MP_PIPE_FLAGS_EN
  logic flag_z, flag_n, flag_v;
`endif

  mp_pipe_if #(.DATA_W(32), .REG_AW(5)) bus ();

  mp_pipe #(.DATA_W(32), .NREG(32), .OPC_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef MP_PIPE_FLAGS_EN
    .flag_z(flag_z),
    .flag_n(flag_n),
    .flag_v(flag_v),
`endif
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [4:0] rd,
                                     input logic [10:0] imm);
    return {imm, rd, rs2, rs1, opc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Drives one instruction; the expectation is queued once it is known the
  // next rising edge will accept it.
  task automatic issue(input logic [31:0] ins, input logic [31:0] res,
                       input logic [4:0] rd, input logic v);
    int cnt = 0;
    @(posedge clk); #1;
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    while (!bus.instr_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!bus.instr_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout instr=0x%08h instr_ready=0 required=1", ins);
    end else begin
      exp_q.push_back('{res: res, rd: rd, v: v});
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
  endtask

  // Monitor: pops one expectation per completed result handshake.
  always @(negedge clk) begin
    if (rst_n && bus.result_valid && bus.result_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=0x%08h rd=%0d required=none",
                 bus.result, bus.result_rd);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (bus.result !== e.res || bus.result_rd !== e.rd) begin
          failures++;
          $display("FAIL result actual=0x%08h/rd%0d required=0x%08h/rd%0d",
                   bus.result, bus.result_rd, e.res, e.rd);
        end
`ifdef MP_PIPE_FLAGS_EN
        checks++;
        if ({flag_z, flag_n, flag_v} !== {(e.res == 32'd0), e.res[31], e.v}) begin
          failures++;
          $display("FAIL flags actual=zNv%b%b%b required=zNv%b%b%b res=0x%08h",
                   flag_z, flag_n, flag_v, (e.res == 32'd0), e.res[31], e.v, e.res);
        end
`endif
      end
    end
  end

  initial begin
    int cnt;
    bus.instr        = '0;
    bus.instr_valid  = 1'b0;
    bus.result_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_result_valid", {31'd0, bus.result_valid}, 32'd0);
    chk("reset_result", bus.result, 32'd0);
    chk("reset_result_rd", {27'd0, bus.result_rd}, 32'd0);
    chk("reset_instr_ready", {31'd0, bus.instr_ready}, 32'd1);

    // back-to-back loads and dependent add
    issue(mk(OP_LDI, 0, 0, 1, 11'h066), 32'h066, 1, 0);
    issue(mk(OP_LDI, 0, 0, 2, 11'h5DC), 32'h5DC, 2, 0);
    issue(mk(OP_ADD, 1, 2, 3, 0), 32'h642, 3, 0);
    issue(mk(OP_OR, 3, 3, 11, 0), 32'h642, 11, 0);

    // dependent chain, including most-negative boundary for neg/abs
    issue(mk(OP_LDI, 0, 0, 4, 11'd5), 32'd5, 4, 0);
    issue(mk(OP_NEG, 4, 0, 5, 0), 32'hFFFF_FFFB, 5, 0);
    issue(mk(OP_ABS, 5, 0, 6, 0), 32'd5, 6, 0);
    issue(mk(OP_AVG, 6, 5, 7, 0), 32'h8000_0000, 7, 0);
    issue(mk(OP_NEG, 7, 0, 21, 0), 32'h8000_0000, 21, 1);
    issue(mk(OP_ABS, 7, 0, 22, 0), 32'h8000_0000, 22, 0);
    idle();

    // backpressure: hold result_ready low while instructions are offered
    fork
      begin
        issue(mk(OP_LDI, 0, 0, 12, 11'h011), 32'h011, 12, 0);
        issue(mk(OP_LDI, 0, 0, 13, 11'h022), 32'h022, 13, 0);
        issue(mk(OP_ADD, 12, 13, 14, 0), 32'h033, 14, 0);
        idle();
      end
      begin
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (!bus.result_valid && cnt < 20) begin
          @(negedge clk);
          cnt++;
        end
        chk("stall_result_valid", {31'd0, bus.result_valid}, 32'd1);
        chk("stall_instr_ready", {31'd0, bus.instr_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_instr_ready_hold", {31'd0, bus.instr_ready}, 32'd0);
          chk("stall_result_hold", bus.result, exp_q[0].res);
          chk("stall_rd_hold", {27'd0, bus.result_rd}, {27'd0, exp_q[0].rd});
        end
        @(posedge clk); #1;
        bus.result_ready = 1'b1;
      end
    join

    // register 0 stays zero
    issue(mk(OP_LDI, 0, 0, 0, 11'h7FF), 32'h7FF, 0, 0);
    issue(mk(OP_OR, 0, 0, 8, 0), 32'd0, 8, 0);

    // illegal opcode: zero result, no write
    issue(mk(OP_LDI, 0, 0, 9, 11'h123), 32'h123, 9, 0);
    issue(mk(OP_BAD, 9, 9, 9, 0), 32'd0, 9, 0);
    issue(mk(OP_OR, 9, 9, 10, 0), 32'h123, 10, 0);

    // small-operand logic ops, then sub with negative result
    issue(mk(OP_LDI, 0, 0, 1, 11'd1), 32'd1, 1, 0);
    issue(mk(OP_LDI, 0, 0, 2, 11'd2), 32'd2, 2, 0);
    issue(mk(OP_MAX, 1, 2, 16, 0), 32'd2, 16, 0);
    issue(mk(OP_MIN, 1, 2, 17, 0), 32'd1, 17, 0);
    issue(mk(OP_XOR, 1, 2, 18, 0), 32'd3, 18, 0);
    issue(mk(OP_AND, 1, 2, 19, 0), 32'd0, 19, 0);
    issue(mk(OP_NOT, 1, 0, 20, 0), 32'hFFFF_FFFE, 20, 0);
    issue(mk(OP_SUB, 1, 2, 3, 0), 32'hFFFF_FFFF, 3, 0);
    issue(mk(OP_LDI, 0, 0, 4, 11'd7), 32'd7, 4, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    // asynchronous reset mid-stream
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    #1;
    chk("async_reset_result_valid", {31'd0, bus.result_valid}, 32'd0);
    chk("async_reset_result", bus.result, 32'd0);
`ifdef MP_PIPE_FLAGS_EN
    chk("async_reset_flags", {29'd0, flag_z, flag_n, flag_v}, 32'd0);
`endif
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // registers were cleared by reset
    issue(mk(OP_OR, 1, 2, 5, 0), 32'd0, 5, 0);
    idle();

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
